// File: rtl/reg_bank_arbiter_pkg.sv
// reg_bank_arbiter_pkg: register bank bus types, response tag and field widths
package reg_bank_arbiter_pkg;
    localparam int REG_SEL_W = 3;
    localparam int REG_DATA_W = 32;
    localparam logic REG_MODE_READ = 1'b0;
    localparam logic REG_MODE_WRITE = 1'b1;
    typedef struct packed {
        logic [REG_DATA_W-1:0] data;
        logic [REG_SEL_W-1:0] sel;
        logic mode;
    } reg_in_bus_t;
    typedef struct packed {
        logic valid;
        logic [2:0] id;
    } rsp_tag_t;
endpackage

// File: rtl/reg_bank_arbiter_if.sv
// reg_bank_arbiter_if: requester-side request/response bundle of the bank arbiter
interface reg_bank_arbiter_if #(parameter int NUM_REQ = 3);
    import reg_bank_arbiter_pkg::*;
    logic [NUM_REQ-1:0] req_valid;
    logic [NUM_REQ-1:0] req_write;
    logic [NUM_REQ-1:0] req_ready;
    logic [NUM_REQ*REG_SEL_W-1:0] req_sel;
    logic [NUM_REQ*REG_DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0] rsp_valid;
    logic [REG_DATA_W-1:0] rsp_data;
    modport master(output req_valid, req_write, req_sel, req_data, input req_ready, rsp_valid, rsp_data);
    modport slave(input req_valid, req_write, req_sel, req_data, output req_ready, rsp_valid, rsp_data);
endinterface

// File: rtl/reg_bank_arbiter_rr_arbiter.sv
// rr_arbiter: one-hot round-robin grant; the pointer moves past the winner on advance
module rr_arbiter #(parameter int N = 3) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant
);
    localparam int PW = $clog2(N);
    logic [PW-1:0] ptr, ptr_next;
    int idx;
    // scan from farthest to nearest offset so the nearest valid requester wins
    always_comb begin
        grant = '0;
        ptr_next = ptr;
        idx = 0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            idx = idx >= N ? idx - N : idx;
            if (req[idx]) begin
                grant = '0;
                grant[idx] = 1'b1;
                ptr_next = idx == N - 1 ? '0 : PW'(idx + 1);
            end
        end
    end
    always_ff @(posedge clk or negedge reset)
        if (!reset) ptr <= '0;
        else if (advance) ptr <= ptr_next;
endmodule

// File: rtl/reg_bank_arbiter.sv
// reg_bank_arbiter: round-robin shares the single-ported register bank, one access per cycle,
// registered bank bus and a tag pipeline that routes read data back to its requester
module reg_bank_arbiter
    import reg_bank_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int READ_LAT = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    reg_bank_arbiter_if.slave     req,
    output reg_in_bus_t           bank_bus,
    input  logic [REG_DATA_W-1:0] bank_q
);
    logic [NUM_REQ-1:0] grant;
    logic hs;
    reg_in_bus_t issue;
    logic [2:0] gid;
    rsp_tag_t [READ_LAT-1:0] tags;
    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .clk(clk),
        .reset(reset),
        .req(req.req_valid),
        .advance(hs),
        .grant(grant)
    );
    assign req.req_ready = grant;
    assign hs = |grant;
    always_comb begin
        issue = '0;
        gid = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (grant[i]) begin
                issue = {req.req_data[i*REG_DATA_W +: REG_DATA_W], req.req_sel[i*REG_SEL_W +: REG_SEL_W], req.req_write[i]};
                gid = 3'(i);
            end
    end
    // idle cycles become harmless reads of the last register
    always_ff @(posedge clk or negedge reset)
        if (!reset) bank_bus <= '0;
        else if (hs) bank_bus <= issue;
        else bank_bus.mode <= REG_MODE_READ;
    always_ff @(posedge clk or negedge reset)
        if (!reset) tags <= '0;
        else begin
            tags[0] <= '{valid: hs && issue.mode != REG_MODE_WRITE, id: gid};
            for (int i = 1; i < READ_LAT; i++) tags[i] <= tags[i-1];
        end
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            req.rsp_valid <= '0;
            req.rsp_data <= '0;
        end else begin
            req.rsp_valid <= tags[READ_LAT-1].valid ? NUM_REQ'(1) << tags[READ_LAT-1].id : '0;
            if (tags[READ_LAT-1].valid) req.rsp_data <= bank_q;
        end
endmodule

// File: tb/tb_reg_bank_arbiter.sv
// tb_reg_bank_arbiter: scoreboard bench for the register bank arbiter with a behavioural bank
module tb_reg_bank_arbiter;
    import reg_bank_arbiter_pkg::*;
    typedef struct {
        int cyc;
        logic [2:0] v;
        logic [31:0] d;
    } ent_t;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int cyc = 0;
    int checks = 0;
    int failures = 0;
    int ptr = 0;
    logic [31:0] mem [8];
    logic [31:0] shadow [8];
    ent_t exp_q [$];
    ent_t obs_q [$];
    reg_in_bus_t bus1, bus2;
    logic [31:0] q1, q2;
    reg_bank_arbiter_if #(.NUM_REQ(3)) if1 ();
    reg_bank_arbiter_if #(.NUM_REQ(3)) if2 ();
    reg_bank_arbiter #(.NUM_REQ(3), .READ_LAT(1)) dut1 (.clk(clk), .reset(reset), .req(if1), .bank_bus(bus1), .bank_q(q1));
    reg_bank_arbiter #(.NUM_REQ(3), .READ_LAT(2)) dut2 (.clk(clk), .reset(reset), .req(if2), .bank_bus(bus2), .bank_q(q2));
    always #5 clk = ~clk;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus1.mode) mem[bus1.sel] <= bus1.data;
    end
    assign q1 = mem[bus1.sel];
    assign q2 = {16'hC0DE, cyc[15:0]};
    always @(negedge clk)
        if (|if1.rsp_valid) obs_q.push_back('{cyc, if1.rsp_valid, if1.rsp_data});

    function automatic int model_grant(logic [2:0] v);
        for (int k = 0; k < 3; k++)
            if (v[(ptr + k) % 3]) return (ptr + k) % 3;
        return -1;
    endfunction

    task automatic model_issue(int g);
        if (g < 0) return;
        ptr = (g + 1) % 3;
        if (if1.req_write[g]) shadow[if1.req_sel[3*g +: 3]] = if1.req_data[32*g +: 32];
        else exp_q.push_back('{cyc + 2, 3'(1 << g), shadow[if1.req_sel[3*g +: 3]]});
    endtask

    task automatic apply(logic [2:0] v, logic [2:0] w, logic [8:0] s, logic [31:0] d);
        if1.req_valid = v;
        if1.req_write = w;
        if1.req_sel = s;
        if1.req_data = {3{d}};
    endtask

    task automatic reset_dut();
        @(negedge clk);
        reset = 1'b0;
        apply(3'b000, 3'b000, 9'd0, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        ptr = 0;
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (bus1 !== '0 || if1.rsp_valid !== 3'b000 || if1.rsp_data !== 32'd0) begin
                failures++;
                $display("FAIL reset_hold bus=%h rsp_valid=%b rsp_data=%h expected all zero", bus1, if1.rsp_valid, if1.rsp_data);
            end
        end
        reset = 1'b1;
        repeat (10) begin
            @(negedge clk);
            #1;
            checks++;
            if (bus1.mode !== 1'b0 || if1.rsp_valid !== 3'b000 || if1.req_ready !== 3'b000) begin
                failures++;
                $display("FAIL reset_idle mode=%b rsp_valid=%b req_ready=%b expected 0/000/000", bus1.mode, if1.rsp_valid, if1.req_ready);
            end
        end
    endtask

    task automatic test_raw_war();
        logic [2:0] tv [5] = '{3'b010, 3'b010, 3'b001, 3'b100, 3'b001};
        logic [2:0] tw [5] = '{3'b010, 3'b000, 3'b000, 3'b100, 3'b000};
        logic [2:0] ts [5] = '{3'd5, 3'd5, 3'd6, 3'd6, 3'd6};
        logic [31:0] td [5] = '{32'hDEADBEEF, 32'd0, 32'd0, 32'h66666666, 32'd0};
        ent_t e, o;
        int g;
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            if (k == 1) begin
                checks++;
                if (bus1 !== {32'hDEADBEEF, 3'd5, 1'b1}) begin
                    failures++;
                    $display("FAIL raw_issue bus=%h expected=%h", bus1, {32'hDEADBEEF, 3'd5, 1'b1});
                end
            end
            apply(tv[k], tw[k], {3{ts[k]}}, td[k]);
            #1;
            g = model_grant(if1.req_valid);
            checks++;
            if (if1.req_ready !== (g < 0 ? 3'b000 : 3'(1 << g))) begin
                failures++;
                $display("FAIL raw_grant row=%0d got=%b expected=%b", k, if1.req_ready, g < 0 ? 3'b000 : 3'(1 << g));
            end
            model_issue(g);
            @(negedge clk);
        end
        apply(3'b000, 3'b000, 9'd0, 32'd0);
        repeat (4) @(negedge clk);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL raw_count got=%0d expected=%0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o.cyc !== e.cyc || o.v !== e.v || o.d !== e.d) begin
                failures++;
                $display("FAIL raw_rsp got cyc=%0d v=%b d=%h expected cyc=%0d v=%b d=%h", o.cyc, o.v, o.d, e.cyc, e.v, e.d);
            end
        end
    endtask

    task automatic test_round_robin();
        ent_t e, o;
        int g;
        reset_dut();
        for (int k = 0; k < 6; k++) begin
            apply(3'b111, 3'b000, {3'd2, 3'd1, 3'd0}, 32'd0);
            #1;
            g = model_grant(if1.req_valid);
            checks++;
            if (if1.req_ready !== 3'(1 << g)) begin
                failures++;
                $display("FAIL rr_grant step=%0d got=%b expected=%b", k, if1.req_ready, 3'(1 << g));
            end
            model_issue(g);
            @(negedge clk);
        end
        apply(3'b000, 3'b000, 9'd0, 32'd0);
        repeat (4) @(negedge clk);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL rr_count got=%0d expected=%0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o.cyc !== e.cyc || o.v !== e.v || o.d !== e.d) begin
                failures++;
                $display("FAIL rr_rsp got cyc=%0d v=%b d=%h expected cyc=%0d v=%b d=%h", o.cyc, o.v, o.d, e.cyc, e.v, e.d);
            end
        end
    endtask

    task automatic test_wrap();
        int g;
        reset_dut();
        for (int k = 0; k < 6; k++) begin
            apply(k < 4 ? 3'b100 : 3'b101, 3'b101, {3'd7, 3'd0, 3'd1}, 32'h70000000 + k);
            #1;
            g = model_grant(if1.req_valid);
            checks++;
            if (if1.req_ready !== 3'(1 << g)) begin
                failures++;
                $display("FAIL wrap_grant step=%0d got=%b expected=%b", k, if1.req_ready, 3'(1 << g));
            end
            model_issue(g);
            @(negedge clk);
        end
        apply(3'b000, 3'b000, 9'd0, 32'd0);
        repeat (3) @(negedge clk);
        checks++;
        if (obs_q.size() != 0) begin
            failures++;
            $display("FAIL wrap_no_rsp got=%0d responses expected=0", obs_q.size());
        end
    endtask

    task automatic test_reset_mid();
        int g;
        reset_dut();
        apply(3'b001, 3'b000, {3'd0, 3'd0, 3'd3}, 32'd0);
        #1;
        g = model_grant(if1.req_valid);
        checks++;
        if (if1.req_ready !== 3'b001) begin
            failures++;
            $display("FAIL mid_grant got=%b expected=001", if1.req_ready);
        end
        model_issue(g);
        @(negedge clk);
        apply(3'b000, 3'b000, 9'd0, 32'd0);
        reset = 1'b0;
        #1;
        checks++;
        if (bus1.mode !== 1'b0 || bus1.sel !== 3'd0 || if1.rsp_valid !== 3'b000) begin
            failures++;
            $display("FAIL mid_async mode=%b sel=%0d rsp_valid=%b expected 0/0/000", bus1.mode, bus1.sel, if1.rsp_valid);
        end
        ptr = 0;
        exp_q.delete();
        repeat (3) @(negedge clk);
        reset = 1'b1;
        apply(3'b101, 3'b101, {3'd1, 3'd0, 3'd1}, 32'h55555555);
        #1;
        g = model_grant(if1.req_valid);
        checks++;
        if (if1.req_ready !== 3'b001) begin
            failures++;
            $display("FAIL mid_first_grant got=%b expected=001", if1.req_ready);
        end
        model_issue(g);
        @(negedge clk);
        apply(3'b000, 3'b000, 9'd0, 32'd0);
        repeat (4) @(negedge clk);
        checks++;
        if (obs_q.size() != 0) begin
            failures++;
            $display("FAIL mid_no_rsp got=%0d responses expected=0", obs_q.size());
        end
    endtask

    task automatic test_read_lat2();
        int t;
        logic [31:0] ed;
        @(negedge clk);
        if2.req_valid = 3'b010;
        if2.req_write = 3'b000;
        if2.req_sel = {3'd0, 3'd4, 3'd0};
        #1;
        checks++;
        if (if2.req_ready !== 3'b010) begin
            failures++;
            $display("FAIL lat2_grant got=%b expected=010", if2.req_ready);
        end
        t = cyc;
        ed = {16'hC0DE, 16'(t + 2)};
        @(negedge clk);
        if2.req_valid = 3'b000;
        checks++;
        if (bus2.sel !== 3'd4 || bus2.mode !== 1'b0 || if2.rsp_valid !== 3'b000) begin
            failures++;
            $display("FAIL lat2_issue sel=%0d mode=%b rsp_valid=%b expected 4/0/000", bus2.sel, bus2.mode, if2.rsp_valid);
        end
        repeat (4) begin
            @(negedge clk);
            checks++;
            if (if2.rsp_valid !== (cyc == t + 3 ? 3'b010 : 3'b000) || (cyc == t + 3 && if2.rsp_data !== ed)) begin
                failures++;
                $display("FAIL lat2_rsp cyc=T+%0d rsp_valid=%b rsp_data=%h expected valid only at T+3 with data %h", cyc - t, if2.rsp_valid, if2.rsp_data, ed);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            mem[i] = 32'h10000000 + i;
            shadow[i] = 32'h10000000 + i;
        end
        apply(3'b000, 3'b000, 9'd0, 32'd0);
        if2.req_valid = 3'b000;
        if2.req_write = 3'b000;
        if2.req_sel = '0;
        if2.req_data = '0;
        test_reset();
        test_raw_war();
        test_round_robin();
        test_wrap();
        test_reset_mid();
        test_read_lat2();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/reg_bank_arbiter.md
Name: reg_bank_arbiter

Overview:
Shares the single-ported 8x32 register bank between NUM_REQ requesters, such as operand fetch, ALU writeback and the program loader. Each cycle the block accepts at most one read or write request, chosen round-robin. It drives the bank's reg_in_bus_t input bus from a register. For reads, it captures the bank's q output and returns the data to the requester that issued the read, tagged with that requester's response strobe. Fully pipelined: one bank access per cycle, no bubbles.

Parameters:
NUM_REQ, 3, number of requesters (2..8)
READ_LAT, 1, cycles from the bus being presented to bank_q being valid and sampled (1..3)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
req_valid  input  NUM_REQ  per-requester request valid
req_write  input  NUM_REQ  1 = write, 0 = read
req_sel  input  NUM_REQ*3  register index, requester i at bits [3i+2:3i]
req_data  input  NUM_REQ*32  write data, requester i at bits [32i+31:32i]
req_ready  output  NUM_REQ  one-hot grant; a handshake occurs when req_valid[i] and req_ready[i] are both high
bank_bus  output  reg_in_bus_t  registered {data, sel, mode} to the register bank
bank_q  input  32  register bank read data
rsp_valid  output  NUM_REQ  one-hot read-response strobe
rsp_data  output  32  read data, shared by all requesters; valid only with rsp_valid

Behaviour:
- Reset (reset low, asynchronous):
  - bank_bus.mode=0, bank_bus.sel=0, bank_bus.data=0
  - rsp_valid=0, rsp_data=0
  - round-robin pointer=0
  - all in-flight reads discarded
  - Reset does not reset the bank's contents; the bank reset is driven separately.
- Grant (combinational, cycle T):
  - Search req_valid starting at the pointer index, wrapping modulo NUM_REQ.
  - Set req_ready for the first valid requester found; all other req_ready bits are 0.
  - No valid requesters gives req_ready=0.
  - req_ready never depends on rsp state; the block never stalls.
- Pointer update: after a handshake by requester g, the pointer becomes (g+1) mod NUM_REQ. Without a handshake it is unchanged.
- Issue (cycle T+1): on a handshake at the T edge, bank_bus = {req_data[g], req_sel[g], req_write[g]}.
- Idle cycles: with no handshake, bank_bus.mode=0 and sel/data hold their previous values. An idle cycle is a harmless read that produces no response.
- Write: the bank latches the data at the end of cycle T+1. No response is generated.
- Read:
  - Tag {valid=1, id=g} enters a READ_LAT-deep shift pipeline at the T edge.
  - bank_q is sampled at the edge that ends cycle T+READ_LAT.
  - In cycle T+READ_LAT+1, rsp_valid[g]=1 and rsp_data holds the sampled value.
  - Total latency for READ_LAT=1: handshake at T, response at T+2.
- Throughput: one handshake per cycle. Back-to-back reads return in issue order, one per cycle.
- Read-after-write, same register, issued on consecutive cycles: the read returns the new value. The write commits before the read's bus cycle, so no forwarding logic is required.
- Write-after-read, same register, issued on consecutive cycles: the read returns the old value.
- A requester holding req_valid high is granted at least once every NUM_REQ cycles (starvation-free).
- req_* may change freely when there is no handshake. Once sampled at a handshake, the request is held internally.
- rsp_data holds its last value when rsp_valid=0.
- Reset asserted mid-operation:
  - Pending responses never appear.
  - After reset deasserts, the first grant goes to the lowest-index valid requester.

Decomposition:
- BusTypes package:
  - existing reg_in_bus_t
  - new constants REG_SEL_W=3, REG_DATA_W=32, REG_MODE_READ=1'b0, REG_MODE_WRITE=1'b1
  - typedef rsp_tag_t {logic valid; logic [2:0] id;}
- Sub-module rr_arbiter #(N):
  - inputs: req vector, advance strobe
  - output: one-hot grant
  - owns the pointer and its asynchronous active-low reset
- reg_bank_arbiter instantiates rr_arbiter and contains the issue register and the tag pipeline.

Test Plan:
1. Reset low for 3 cycles, then release with all req_valid=0. Required: bank_bus.mode=0, rsp_valid=0, req_ready=0 for 10 cycles.
2. Requester 1 writes sel=5, data=32'hDEADBEEF at T, then reads sel=5 at T+1. Required: bank_bus = {DEADBEEF, 5, 1} at T+1; rsp_valid=3'b010 with rsp_data=32'hDEADBEEF at T+3.
3. All 3 requesters hold read requests (sel=0,1,2) continuously. Required grant order: 0,1,2,0,1,2. rsp_valid is one-hot each cycle in that same order, starting 2 cycles after the first grant.
4. Only requester 2 is valid for 4 cycles, then requesters 0 and 2 are both valid. Required: the pointer has wrapped to 0, so requester 0 is granted first, then requester 2.
5. Requester 0 reads sel=3 at T. Drive reset low at the middle of T+1 and release it at T+4. Required: no rsp_valid at any time; bank_bus.mode=0 immediately on reset assertion.
6. With READ_LAT=2, a read at T. Required: rsp_valid at T+3, and rsp_data equals the bank_q value sampled at the end of T+2.
